// File: rtl/sbuf_pingpong.sv
// Double-buffered (ping-pong) operand buffer: writer fills one bank while the reader drains the other.
// Optional macro SBUF_PARITY_EN adds a stored even-parity bit per word and drives par_err.
module sbuf_pingpong #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_done,
    output logic          wr_bank_free,
    output logic          wr_sel,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_done,
    output logic          rd_bank_ready,
    output logic          rd_sel,
    output logic [1:0]    bank_cnt,
    output logic          par_err
);

`ifdef SBUF_PARITY_EN
    localparam int unsigned RW = DW + 1;
`else
    localparam int unsigned RW = DW;
`endif
    localparam int unsigned DEPTH = 2 * (2 ** AW);

    logic [RW-1:0] mem [DEPTH];

    logic [1:0]    full_q, full_d;
    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          wr_free, rd_ready;
    logic          wr_ok, rd_ok, wr_commit, rd_release;
    logic [RW-1:0] wr_word, rd_word;

    always_comb begin
        wr_free    = !full_q[wsel_q];
        rd_ready   = full_q[rsel_q];
        wr_ok      = wr_en   && wr_free;
        wr_commit  = wr_done && wr_free;
        rd_ok      = rd_en   && rd_ready;
        rd_release = rd_done && rd_ready;

        // When wsel==rsel only one of commit/release can be enabled, so the two updates never collide.
        full_d = full_q;
        if (wr_commit)  full_d[wsel_q] = 1'b1;
        if (rd_release) full_d[rsel_q] = 1'b0;
        wsel_d = wsel_q ^ wr_commit;
        rsel_d = rsel_q ^ rd_release;

        rd_word    = mem[{rsel_q, rd_adr}];
        rd_valid_d = rd_ok;
        rd_data_d  = rd_ok ? rd_word[DW-1:0] : rd_data_q;
`ifdef SBUF_PARITY_EN
        wr_word = {^wr_data, wr_data};
`else
        wr_word = wr_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wsel_q, wr_adr}] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            full_q     <= full_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef SBUF_PARITY_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = rd_ok && ((^rd_word[DW-1:0]) != rd_word[DW]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign wr_bank_free  = wr_free;
    assign rd_bank_ready = rd_ready;
    assign wr_sel        = wsel_q;
    assign rd_sel        = rsel_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign bank_cnt      = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_sbuf_pingpong.sv
// Self-checking bench for sbuf_pingpong: directed scenarios plus random traffic against a
// count-based bank model (full-bank count with alternating write/read pointers).
module tb_sbuf_pingpong;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [DW-1:0] wr_data;
    logic          wr_bank_free, wr_sel, rd_valid, rd_bank_ready, rd_sel, par_err;
    logic [DW-1:0] rd_data;
    logic [1:0]    bank_cnt;

    sbuf_pingpong #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .wr_done(wr_done),
        .wr_bank_free(wr_bank_free), .wr_sel(wr_sel),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_done(rd_done), .rd_bank_ready(rd_bank_ready), .rd_sel(rd_sel),
        .bank_cnt(bank_cnt), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: number of full banks plus the two alternating bank pointers.
    logic [15:0] mem_m [512];
    bit          bad_m [512];
    int          n;
    bit          wp, rp;
    bit          exp_valid, exp_par;
    logic [15:0] exp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("wr_bank_free",  32'(wr_bank_free),  32'(n != 2));
        check("rd_bank_ready", 32'(rd_bank_ready), 32'(n != 0));
        check("bank_cnt",      32'(bank_cnt),      32'(n));
        check("wr_sel",        32'(wr_sel),        32'(wp));
        check("rd_sel",        32'(rd_sel),        32'(rp));
        check("rd_valid",      32'(rd_valid),      32'(exp_valid));
        check("rd_data",       32'(rd_data),       32'(exp_data));
        check("par_err",       32'(par_err),       32'(exp_par));
    endtask

    task automatic model_reset();
        n = 0; wp = 1'b0; rp = 1'b0;
        exp_valid = 1'b0; exp_par = 1'b0; exp_data = '0;
    endtask

    task automatic step(input logic we, input logic wd, input logic [7:0] wa, input logic [15:0] wdat,
                        input logic re, input logic rdn, input logic [7:0] ra);
        bit wfree, rready;
        int wi, ri;
        wr_en = we; wr_done = wd; wr_adr = wa; wr_data = wdat;
        rd_en = re; rd_done = rdn; rd_adr = ra;
        @(posedge clk);
        wfree  = (n != 2);
        rready = (n != 0);
        wi = int'(wp) * 256 + int'(wa);
        ri = int'(rp) * 256 + int'(ra);
        exp_valid = re && rready;
        exp_par   = 1'b0;
        if (exp_valid) begin
            exp_data = mem_m[ri];
            exp_par  = bad_m[ri];
        end
        if (we && wfree) begin
            mem_m[wi] = wdat;
            bad_m[wi] = 1'b0;
        end
        if (wd && wfree)   begin n++; wp = !wp; end
        if (rdn && rready) begin n--; rp = !rp; end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        foreach (bad_m[i]) bad_m[i] = 1'b0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_done = 1'b0; wr_adr = '0; wr_data = '0;
        rd_en = 1'b0; rd_done = 1'b0; rd_adr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        idle();

        // Bank 0 fill; wr_done rides on the last write, which must land in bank 0.
        for (int a = 0; a < 256; a++)
            step(1'b1, a == 255, 8'(a), 16'(a) ^ 16'hA5A5, 1'b0, 1'b0, 8'd0);
        check("fill0_wr_sel", 32'(wr_sel), 32'd1);
        check("fill0_cnt", 32'(bank_cnt), 32'd1);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd0);
        check("rd0_a0", 32'(rd_data), 32'hA5A5);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd1);
        check("rd0_a1", 32'(rd_data), 32'hA5A4);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd255);
        check("rd0_a255", 32'(rd_data), 32'hA55A);
        idle();

        for (int a = 0; a < 256; a++)
            step(1'b1, a == 255, 8'(a), 16'hFFFF ^ 16'(a), 1'b0, 1'b0, 8'd0);
        check("both_full_cnt", 32'(bank_cnt), 32'd2);
        step(1'b1, 1'b1, 8'd3, 16'h0000, 1'b0, 1'b0, 8'd0);
        check("full_drop_cnt", 32'(bank_cnt), 32'd2);
        check("full_drop_free", 32'(wr_bank_free), 32'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd3);
        check("rd0_a3_kept", 32'(rd_data), 32'hA5A6);

        // Release bank 0, then refill it while bank 1 is read, with simultaneous done pulses.
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 8'd0);
        for (int a = 0; a < 4; a++)
            step(1'b1, 1'b0, 8'(a), 16'($urandom), 1'b1, 1'b0, 8'd0);
        check("rd1_a0", 32'(rd_data), 32'hFFFF);
        step(1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b1, 8'd0);
        check("simul1_cnt", 32'(bank_cnt), 32'd1);
        step(1'b0, 1'b1, 8'd0, 16'd0, 1'b1, 1'b1, 8'd9);
        check("simul2_cnt", 32'(bank_cnt), 32'd1);
        check("simul2_rd_sel", 32'(rd_sel), 32'd1);
        check("simul2_wr_sel", 32'(wr_sel), 32'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd0);
        check("rd1_a0_again", 32'(rd_data), 32'hFFFF);

        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b1, 8'd5);
        check("empty_rd_valid", 32'(rd_valid), 32'd0);
        check("empty_cnt", 32'(bank_cnt), 32'd0);

        // Asynchronous reset in the middle of a fill, checked before the next edge.
        for (int a = 0; a < 10; a++)
            step(1'b1, 1'b0, 8'(a), 16'($urandom), 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd2);
        wr_en = 1'b0; rd_en = 1'b1; rd_adr = 8'd4;
        #2 rst_n = 1'b0;
        #1;
        check("arst_free", 32'(wr_bank_free), 32'd1);
        check("arst_ready", 32'(rd_bank_ready), 32'd0);
        check("arst_cnt", 32'(bank_cnt), 32'd0);
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_data", 32'(rd_data), 32'd0);
        check("arst_wr_sel", 32'(wr_sel), 32'd0);
        check("arst_rd_sel", 32'(rd_sel), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_valid_hold", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        idle();

`ifdef SBUF_PARITY_EN
        step(1'b1, 1'b1, 8'd7, 16'h0001, 1'b0, 1'b0, 8'd0);
        dut.mem[7][0] = ~dut.mem[7][0];
        mem_m[7] = 16'h0000;
        bad_m[7] = 1'b1;
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd7);
        check("par_flip", 32'(par_err), 32'd1);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 8'd8);
        check("par_clean", 32'(par_err), 32'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 8'd0);
`else
        step(1'b1, 1'b1, 8'd7, 16'h0001, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b1, 8'd7);
        check("par_off", 32'(par_err), 32'd0);
`endif

        for (int c = 0; c < 3000; c++)
            step(1'($urandom_range(1, 0)), $urandom_range(19, 0) == 0, 8'($urandom), 16'($urandom),
                 1'($urandom_range(1, 0)), $urandom_range(19, 0) == 0, 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbuf_pingpong.md
Name: sbuf_pingpong

Overview:
- Parametrised double-buffered (ping-pong) 1-read/1-write operand buffer that stages matrix rows/columns in front of the systolic array.
- The writer side (host/DMA loader) fills one bank while the array side drains the other.
- Ownership of the two banks is exchanged by a done/ready handshake on each side.
- Read latency and addressing match the existing single-bank scratch buffers, so the array-side read path is drop-in.

Parameters:
- DW, 16, data word width in bits.
- AW, 8, address width; each bank holds 2**AW words; total storage 2*2**AW words.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe into the current write bank.
- wr_adr  input  AW  word address within the write bank.
- wr_data  input  DW  write data.
- wr_done  input  1  one-cycle pulse: writer has finished filling the current write bank.
- wr_bank_free  output  1  current write bank is free and may be written.
- wr_sel  output  1  index of the current write bank.
- rd_en  input  1  read strobe from the current read bank.
- rd_adr  input  AW  word address within the read bank.
- rd_data  output  DW  read data, registered.
- rd_valid  output  1  rd_data holds the result of a read accepted on the previous cycle.
- rd_done  input  1  one-cycle pulse: reader has finished with the current read bank.
- rd_bank_ready  output  1  current read bank is full and may be read.
- rd_sel  output  1  index of the current read bank.
- bank_cnt  output  2  number of full banks (0..2).
- par_err  output  1  parity error on the word presented this cycle (see Optional Feature).

Behaviour:
- State: full[1:0], wsel, rsel, rd_valid, rd_data. The RAM array is not reset.
- Reset (rst_n=0, asynchronous):
  - full=00, wsel=0, rsel=0.
  - wr_bank_free=1, rd_bank_ready=0, bank_cnt=0.
  - rd_valid=0, rd_data=0, par_err=0.
- Derived outputs:
  - wr_bank_free = !full[wsel].
  - rd_bank_ready = full[rsel].
  - bank_cnt = full[0]+full[1].
  - wr_sel=wsel, rd_sel=rsel.
- Write:
  - wr_en && wr_bank_free writes wr_data to bank wsel, address wr_adr.
  - wr_en while !wr_bank_free is dropped silently; no RAM change.
- Write commit:
  - wr_done && wr_bank_free: full[wsel] <= 1 and wsel <= ~wsel on the same edge.
  - wr_done while !wr_bank_free is ignored.
  - wr_en and wr_done in the same cycle: the write lands in the old bank, then the swap takes effect.
- Read:
  - rd_en && rd_bank_ready reads bank rsel at rd_adr.
  - rd_data is updated on the next edge with rd_valid=1 that cycle. Latency is exactly 1 cycle.
  - Without an accepted read, rd_valid=0 and rd_data holds its last value.
  - rd_en while !rd_bank_ready is ignored: rd_valid=0 next cycle.
- Read release:
  - rd_done && rd_bank_ready: full[rsel] <= 0 and rsel <= ~rsel.
  - rd_done while !rd_bank_ready is ignored.
  - rd_en and rd_done in the same cycle: the read is served from the old bank, data appears next cycle, then the swap takes effect.
- Simultaneous wr_done and rd_done: both apply on the same edge. Their targets are always different banks, so there is no conflict and bank_cnt is unchanged.
- Invariant: when wsel==rsel, full[wsel] is either 0 (writer may proceed, reader stalls) or 1 (reader proceeds, writer stalls). Reading and writing the same bank concurrently is therefore impossible, and no read-during-write bypass is needed.
- Bank sequencing: strict alternation 0,1,0,1 on both sides. Neither side ever skips a bank.
- Reset mid-operation: all flags and selects return to reset values immediately. Banks are treated as empty even though RAM contents persist. Any read in flight produces no rd_valid.

Optional Feature:
- Macro: SBUF_PARITY_EN.
- Defined:
  - Each RAM word is DW+1 bits wide and stores even parity over wr_data.
  - On an accepted read, parity is recomputed over the stored data bits.
  - par_err=1 in the rd_valid cycle if it mismatches the stored parity bit; otherwise par_err=0.
  - rd_data is still delivered unchanged.
- Undefined: RAM is DW bits wide and par_err is tied to 0.

Test Plan:
- Reset, then idle -> wr_bank_free=1, rd_bank_ready=0, bank_cnt=0, rd_valid=0, wr_sel=rd_sel=0.
- Write addr 0..255 with data=addr^16'hA5A5 into bank 0, then pulse wr_done -> wr_sel=1, rd_bank_ready=1, bank_cnt=1. Read addr 0,1,255 -> rd_data 16'hA5A5, 16'hA5A4, 16'hA55A, each one cycle after rd_en with rd_valid=1.
- Fill both banks (bank1 data=~addr), then attempt a write to addr 3 plus a wr_done -> both ignored: bank_cnt=2, wr_bank_free=0, bank0 addr 3 still reads 16'hA5A6.
- While reading bank 0, the writer refills: pulse rd_done and wr_done in the same cycle with bank_cnt=1 -> bank_cnt stays 1, rd_sel=1, wr_sel=0. Read of bank 1 addr 0 returns 16'hFFFF.
- Assert rd_en with rd_bank_ready=0, and rd_done at empty -> rd_valid=0, no state change. Drop rst_n mid-fill -> all outputs at reset values asynchronously, before the next clock.
- With SBUF_PARITY_EN: write 16'h0001, flip one stored data bit via hierarchical access, read it -> par_err=1 with rd_valid. An unmodified word gives par_err=0. Without the macro, par_err stays 0.
